// File: rtl/axis_if.sv
// axis_if: two-entry AXI4-Stream register slice (skid buffer).
//
// A main register drives the m_* outputs and a skid register catches the one
// beat that can arrive in the cycle after downstream stalls. Both handshake
// outputs (s_tready, m_tvalid) and occupancy come straight from flip-flops,
// so there is no combinational path from m_tready to s_tready.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   s_tvalid/s_tready/s_tdata/s_tkeep/s_tlast/s_tuser   upstream beat
//   m_tvalid/m_tready/m_tdata/m_tkeep/m_tlast/m_tuser   downstream beat
//   occupancy       beats currently held (0, 1 or 2)
module axis_if #(
  parameter int TDATA_WIDTH = 32,
  parameter int TUSER_WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic [TDATA_WIDTH-1:0]   s_tdata,
  input  logic [TDATA_WIDTH/8-1:0] s_tkeep,
  input  logic                     s_tlast,
  input  logic [TUSER_WIDTH-1:0]   s_tuser,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [TDATA_WIDTH-1:0]   m_tdata,
  output logic [TDATA_WIDTH/8-1:0] m_tkeep,
  output logic                     m_tlast,
  output logic [TUSER_WIDTH-1:0]   m_tuser,
  output logic [1:0]               occupancy
);

  localparam int KEEP_WIDTH = TDATA_WIDTH / 8;
  localparam int BEAT_WIDTH = TDATA_WIDTH + KEEP_WIDTH + 1 + TUSER_WIDTH;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  next_state_s;
  logic [BEAT_WIDTH-1:0]   main_r;
  logic [BEAT_WIDTH-1:0]   skid_r;
  logic [BEAT_WIDTH-1:0]   in_beat_s;
  logic                    s_tready_r;
  logic                    m_tvalid_r;
  logic [1:0]              occupancy_r;
  logic                    up_xfer_s;
  logic                    dn_xfer_s;
  logic                    load_main_s;
  logic                    load_skid_s;
  logic                    main_from_skid_s;

  // Number of beats held in a given state.
  function automatic logic [1:0] occ_of(input state_t st);
    logic [1:0] occ;
    case (st)
      EMPTY:   occ = 2'd0;
      BUSY:    occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

  // The whole beat moves as one word so its fields can never be split.
  assign in_beat_s = {s_tuser, s_tlast, s_tkeep, s_tdata};
  assign up_xfer_s = s_tvalid & s_tready_r;
  assign dn_xfer_s = m_tvalid_r & m_tready;

  // Next-state and register-load decode.
  always_comb begin
    next_state_s     = state_r;
    load_main_s      = 1'b0;
    load_skid_s      = 1'b0;
    main_from_skid_s = 1'b0;
    case (state_r)
      EMPTY: begin
        if (up_xfer_s) begin
          load_main_s  = 1'b1;
          next_state_s = BUSY;
        end else begin
          next_state_s = EMPTY;
        end
      end
      BUSY: begin
        if (up_xfer_s && dn_xfer_s) begin
          load_main_s  = 1'b1;
          next_state_s = BUSY;
        end else if (up_xfer_s) begin
          // Downstream stalled: park the new beat behind the one on m_*.
          load_skid_s  = 1'b1;
          next_state_s = FULL;
        end else if (dn_xfer_s) begin
          next_state_s = EMPTY;
        end else begin
          next_state_s = BUSY;
        end
      end
      FULL: begin
        // s_tready is low here, so no upstream beat can arrive.
        if (dn_xfer_s) begin
          main_from_skid_s = 1'b1;
          next_state_s     = BUSY;
        end else begin
          next_state_s = FULL;
        end
      end
      default: begin
        next_state_s = EMPTY;
      end
    endcase
  end

  // State, payload and registered handshake/occupancy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= EMPTY;
      main_r      <= {BEAT_WIDTH{1'b0}};
      skid_r      <= {BEAT_WIDTH{1'b0}};
      s_tready_r  <= 1'b0;
      m_tvalid_r  <= 1'b0;
      occupancy_r <= 2'd0;
    end else begin
      state_r     <= next_state_s;
      s_tready_r  <= (next_state_s != FULL);
      m_tvalid_r  <= (next_state_s != EMPTY);
      occupancy_r <= occ_of(next_state_s);
      if (load_main_s) begin
        main_r <= in_beat_s;
      end else if (main_from_skid_s) begin
        main_r <= skid_r;
      end else begin
        main_r <= main_r;
      end
      if (load_skid_s) begin
        skid_r <= in_beat_s;
      end else begin
        skid_r <= skid_r;
      end
    end
  end

  assign s_tready  = s_tready_r;
  assign m_tvalid  = m_tvalid_r;
  assign occupancy = occupancy_r;
  assign m_tdata   = main_r[TDATA_WIDTH-1:0];
  assign m_tkeep   = main_r[TDATA_WIDTH +: KEEP_WIDTH];
  assign m_tlast   = main_r[TDATA_WIDTH + KEEP_WIDTH];
  assign m_tuser   = main_r[BEAT_WIDTH-1 -: TUSER_WIDTH];

endmodule

// File: tb/tb_axis_if.sv
// Testbench for axis_if: randomized stimulus, queue-based reference model and
// a negedge monitor that checks every downstream beat against the queue.
module tb_axis_if;

  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int UW = 2;
  localparam int BW = DW + KW + 1 + UW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic          s_tlast = 1'b0;
  logic [UW-1:0] s_tuser = '0;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tlast;
  logic [UW-1:0] m_tuser;
  logic [1:0]    occupancy;

  int checks   = 0;
  int failures = 0;

  // Reference model: beats accepted upstream and not yet delivered, in order.
  logic [BW-1:0] exp_q[$];

  logic          rst_q = 1'b1;
  logic          prev_stall = 1'b0;
  logic [BW-1:0] prev_beat = '0;

  axis_if #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tuser(m_tuser),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rst_q <= rst;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] rand_beat();
    logic [BW-1:0] b;
    b = {$urandom_range(3, 0), $urandom_range(1, 0), $urandom_range(15, 0), $urandom()};
    return b;
  endfunction

  // Monitor: compare DUT state against the model, pop on each downstream transfer.
  always @(negedge clk) begin
    int held;
    logic [BW-1:0] cur;
    logic [BW-1:0] exp;
    cur = {m_tuser, m_tlast, m_tkeep, m_tdata};
    if (rst || rst_q) begin
      prev_stall = 1'b0;
    end else begin
      // The tail of the queue may be a beat that transfers at the coming edge.
      held = exp_q.size() - ((s_tvalid && s_tready) ? 1 : 0);
      chk("occupancy", 64'(occupancy), 64'(held));
      chk("m_tvalid", 64'(m_tvalid), 64'(held != 0));
      chk("s_tready", 64'(s_tready), 64'(held < 2));
      if (prev_stall) chk("stable_while_stalled", 64'(cur), 64'(prev_beat));
      if (m_tvalid && m_tready) begin
        if (held == 0) begin
          chk("unexpected_beat", 64'(cur), 64'(0));
        end else begin
          exp = exp_q.pop_front();
          chk("beat", 64'(cur), 64'(exp));
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = cur;
    end
  end

  // One driven cycle; returns whether the beat will be taken at the next edge.
  task automatic cycle(input logic v, input logic [BW-1:0] b, input logic mr, output logic acc);
    @(posedge clk);
    #1;
    s_tvalid = v;
    {s_tuser, s_tlast, s_tkeep, s_tdata} = b;
    m_tready = mr;
    acc = v && s_tready;
    if (acc) exp_q.push_back(b);
  endtask

  task automatic send(input logic [BW-1:0] b, input logic mr);
    logic acc;
    int n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 100) begin
      cycle(1'b1, b, mr, acc);
      n++;
    end
    if (!acc) chk("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic idle(input int n, input logic mr);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, mr, acc);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst = 1'b1;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
      chk("rst_occupancy", 64'(occupancy), 64'(0));
      chk("rst_s_tready", 64'(s_tready), 64'(0));
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_s_tready", 64'(s_tready), 64'(1));
    chk("post_rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("post_rst_occupancy", 64'(occupancy), 64'(0));
  endtask

  initial begin
    logic [BW-1:0] a, b, c;
    logic acc;
    int sent, cyc;

    // Reset held for two cycles.
    do_reset(2);

    // Single beat.
    send({2'd0, 1'b1, 4'hF, 32'hDEADBEEF}, 1'b1);
    idle(3, 1'b1);

    // Streaming 0..15 back-to-back.
    for (int i = 0; i < 16; i++) send({2'(i), 1'(i == 15), 4'hF, 32'(i)}, 1'b1);
    idle(3, 1'b1);

    // Backpressure: A and B fill the slice, C is held off.
    a = rand_beat();
    b = rand_beat();
    c = rand_beat();
    send(a, 1'b0);
    send(b, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, c, 1'b0, acc);
      chk("c_held_off", 64'(acc), 64'(0));
    end
    send(c, 1'b1);
    idle(4, 1'b1);

    // Random stress: 50% s_tvalid, 50% m_tready.
    sent = 0;
    cyc = 0;
    a = rand_beat();
    while (sent < 1000 && cyc < 20000) begin
      cycle(1'($urandom_range(1, 0)), a, 1'($urandom_range(1, 0)), acc);
      if (acc) begin
        sent++;
        a = rand_beat();
      end
      cyc++;
    end
    chk("stress_sent", 64'(sent), 64'(1000));
    idle(5, 1'b1);

    // Reset while FULL; only beats sent afterwards may appear.
    send(rand_beat(), 1'b0);
    send(rand_beat(), 1'b0);
    idle(1, 1'b0);
    do_reset(1);
    for (int i = 0; i < 4; i++) send(rand_beat(), 1'($urandom_range(1, 0)));
    idle(6, 1'b1);

    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
